// File: rtl/cpu_types_pkg.sv
// Shared CPU types: memory words, RAM handshake states and the
// memory controller FSM encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IBUS  = 3'd1,
        DBUS  = 3'd2,
        IDONE = 3'd3,
        DDONE = 3'd4,
        ABORT = 3'd5
    } memctl_state_t;

endpackage

// File: rtl/memctl_timer.sv
// Access watchdog: counts bus cycles of the current grant and flags
// the last allowed cycle. Saturates instead of wrapping.
module memctl_timer #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expire
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] MAX = W'(TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    // Clear on grant, count while on the bus, hold at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_en && (r_cnt == MAX);

endmodule

// File: rtl/memory_control.sv
// Arbitrates icache and dcache requests onto one single-ported RAM
// and returns done pulses and load data to the caches.
module memory_control
    import cpu_types_pkg::*;
#(
    parameter int    TIMEOUT  = 256,
    parameter word_t BAD_WORD = 32'hBAD1BAD1
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output word_t     iload,
    output logic      iwait,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output word_t     dload,
    output logic      dwait,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      memerr
);

    memctl_state_t r_state;
    memctl_state_t w_next;

    word_t r_addr;
    word_t r_store;
    word_t r_iload;
    word_t r_dload;
    logic  r_wr;
    logic  r_own_d;
    logic  r_last_d;
    logic  r_memerr;

    logic w_dpend;
    logic w_bus;
    logic w_grant;
    logic w_grant_d;
    logic w_abort;
    logic w_expire;

    assign w_dpend   = dREN | dWEN;
    assign w_bus     = (r_state == IBUS) || (r_state == DBUS);
    assign w_grant   = (r_state == IDLE) && (w_next != IDLE);
    assign w_grant_d = (r_state == IDLE) && (w_next == DBUS);
    assign w_abort   = w_bus && (w_next == ABORT);

    memctl_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (CLK),
        .rst_n    (nRST),
        .i_clear  (w_grant),
        .i_en     (w_bus),
        .o_expire (w_expire)
    );

    // Next state: dcache wins ties unless it had the previous grant
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_dpend && !(iREN && r_last_d)) begin
                    w_next = DBUS;
                end else if (iREN) begin
                    w_next = IBUS;
                end
            end
            IBUS, DBUS: begin
                if (ramstate == ACCESS) begin
                    w_next = (r_state == IBUS) ? IDONE : DDONE;
                end else if ((ramstate == ERROR) || w_expire) begin
                    w_next = ABORT;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch the granted operation so requester changes cannot corrupt it
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_addr   <= '0;
            r_store  <= '0;
            r_wr     <= 1'b0;
            r_own_d  <= 1'b0;
            r_last_d <= 1'b0;
        end else if (w_grant) begin
            r_addr   <= w_grant_d ? daddr : iaddr;
            r_store  <= w_grant_d ? dstore : r_store;
            r_wr     <= w_grant_d && dWEN;
            r_own_d  <= w_grant_d;
            r_last_d <= w_grant_d;
        end
    end

    // Load words: captured read data, or the poison word on an aborted read
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_iload <= '0;
            r_dload <= '0;
        end else if (w_abort && !r_wr) begin
            if (r_own_d) begin
                r_dload <= BAD_WORD;
            end else begin
                r_iload <= BAD_WORD;
            end
        end else if (w_bus && (ramstate == ACCESS) && !r_wr) begin
            if (r_own_d) begin
                r_dload <= ramload;
            end else begin
                r_iload <= ramload;
            end
        end
    end

    // Sticky error: aborted access or conflicting read+write request
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_memerr <= 1'b0;
        end else if (w_abort || (w_grant_d && dREN && dWEN)) begin
            r_memerr <= 1'b1;
        end
    end

    assign ramREN   = w_bus && !r_wr;
    assign ramWEN   = w_bus && r_wr;
    assign ramaddr  = r_addr;
    assign ramstore = r_store;
    assign iload    = r_iload;
    assign dload    = r_dload;
    assign memerr   = r_memerr;
    assign iwait    = !((r_state == IDONE) ||
                        ((r_state == ABORT) && !r_own_d));
    assign dwait    = !((r_state == DDONE) ||
                        ((r_state == ABORT) && r_own_d));

endmodule

// File: tb/tb_memory_control.sv
// Directed bench for memory_control: reads, writes, arbitration,
// timeout abort, async reset and conflicting dcache requests.
module tb_memory_control;
    import cpu_types_pkg::*;

    logic      CLK;
    logic      nRST;
    logic      iREN;
    word_t     iaddr;
    word_t     iload;
    logic      iwait;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    word_t     dload;
    logic      dwait;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      memerr;

    int checks = 0;
    int errors = 0;

    memory_control #(
        .TIMEOUT  (8),
        .BAD_WORD (32'hBAD1BAD1)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .memerr   (memerr)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs;
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = FREE;
    endtask

    task automatic do_reset;
        idle_inputs();
        nRST = 0;
        #2;
        nRST = 1;
        tick();
    endtask

    task automatic test_reset;
        idle_inputs();
        nRST = 0;
        iREN = 1; dREN = 1;
        #3;
        tick();
        tick();
        checks++; if (iwait !== 1'b1) begin errors++; $display("FAIL rst_iwait got %b want 1", iwait); end
        checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL rst_dwait got %b want 1", dwait); end
        checks++; if ({ramREN, ramWEN, memerr} !== 3'b000) begin errors++; $display("FAIL rst_ctl got %b want 000", {ramREN, ramWEN, memerr}); end
        checks++; if ({iload, dload} !== 64'h0) begin errors++; $display("FAIL rst_loads got %h want 0", {iload, dload}); end
        checks++; if ({ramaddr, ramstore} !== 64'h0) begin errors++; $display("FAIL rst_ram got %h want 0", {ramaddr, ramstore}); end
        idle_inputs();
        #3;
        nRST = 1;
        tick();
    endtask

    task automatic test_iread;
        iREN = 1; iaddr = 32'h40;
        ramstate = ACCESS; ramload = 32'h8C010004;
        checks++; if (iwait !== 1'b1) begin errors++; $display("FAIL ird_c0_iwait got %b want 1", iwait); end
        tick();
        checks++; if ({ramREN, ramWEN} !== 2'b10) begin errors++; $display("FAIL ird_c1_en got %b want 10", {ramREN, ramWEN}); end
        checks++; if (ramaddr !== 32'h40) begin errors++; $display("FAIL ird_c1_addr got %h want 40", ramaddr); end
        tick();
        checks++; if (iwait !== 1'b0) begin errors++; $display("FAIL ird_c2_iwait got %b want 0", iwait); end
        checks++; if (iload !== 32'h8C010004) begin errors++; $display("FAIL ird_c2_iload got %h want 8c010004", iload); end
        iREN = 0;
        tick();
        checks++; if ({iwait, ramREN} !== 2'b10) begin errors++; $display("FAIL ird_c3 got %b want 10", {iwait, ramREN}); end
        checks++; if (iload !== 32'h8C010004) begin errors++; $display("FAIL ird_hold got %h want 8c010004", iload); end
        idle_inputs();
    endtask

    task automatic test_dwrite_busy;
        dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        ramstate = BUSY;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 4) ramstate = ACCESS;
            checks++; if ({ramWEN, ramREN, dwait} !== 3'b101) begin errors++; $display("FAIL dwr_c%0d_ctl got %b want 101", c, {ramWEN, ramREN, dwait}); end
            checks++; if ({ramaddr, ramstore} !== {32'h100, 32'hDEADBEEF}) begin errors++; $display("FAIL dwr_c%0d_bus got %h want 00000100deadbeef", c, {ramaddr, ramstore}); end
        end
        tick();
        checks++; if (dwait !== 1'b0) begin errors++; $display("FAIL dwr_c5_dwait got %b want 0", dwait); end
        dWEN = 0;
        tick();
        checks++; if ({dwait, ramWEN, memerr} !== 3'b100) begin errors++; $display("FAIL dwr_c6 got %b want 100", {dwait, ramWEN, memerr}); end
        idle_inputs();
    endtask

    task automatic test_arbitration;
        byte got[4];
        byte want[4];
        int  n;
        want = '{"D", "I", "D", "I"};
        n = 0;
        do_reset();
        iREN = 1; iaddr = 32'h200;
        dREN = 1; daddr = 32'h300;
        ramstate = ACCESS; ramload = 32'h55;
        for (int c = 0; c < 12 && n < 4; c++) begin
            tick();
            if (!iwait && !dwait) begin
                checks++; errors++;
                $display("FAIL arb_both_done at cycle %0d", c);
            end else if (!dwait) begin
                got[n] = "D"; n++;
            end else if (!iwait) begin
                got[n] = "I"; n++;
            end
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL arb_count got %0d want 4 in 12 cycles", n); end
        for (int k = 0; k < 4; k++) begin
            if (k < n) begin
                checks++; if (got[k] !== want[k]) begin errors++; $display("FAIL arb_grant%0d got %c want %c", k, got[k], want[k]); end
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_drop_midaccess;
        iREN = 1; iaddr = 32'h88; ramstate = BUSY;
        tick();
        iREN = 0; iaddr = 32'hFFF;
        tick();
        checks++; if ({ramREN, ramaddr} !== {1'b1, 32'h88}) begin errors++; $display("FAIL drop_bus got %h want 100000088", {ramREN, ramaddr}); end
        ramstate = ACCESS; ramload = 32'h0A0B0C0D;
        tick();
        checks++; if ({iwait, iload} !== {1'b0, 32'h0A0B0C0D}) begin errors++; $display("FAIL drop_done got %h want 00a0b0c0d", {iwait, iload}); end
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout;
        checks++; if (memerr !== 1'b0) begin errors++; $display("FAIL to_pre_memerr got %b want 0", memerr); end
        dREN = 1; daddr = 32'h80; ramstate = BUSY;
        for (int c = 1; c <= 8; c++) begin
            tick();
            checks++; if ({ramREN, dwait, memerr} !== 3'b110) begin errors++; $display("FAIL to_bus%0d got %b want 110", c, {ramREN, dwait, memerr}); end
        end
        tick();
        checks++; if ({dwait, ramREN} !== 2'b00) begin errors++; $display("FAIL to_abort_ctl got %b want 00", {dwait, ramREN}); end
        checks++; if (dload !== 32'hBAD1BAD1) begin errors++; $display("FAIL to_dload got %h want bad1bad1", dload); end
        dREN = 0;
        tick();
        checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL to_after_dwait got %b want 1", dwait); end
        tick();
        tick();
        checks++; if ({memerr, dload} !== {1'b1, 32'hBAD1BAD1}) begin errors++; $display("FAIL to_sticky got %h want 1bad1bad1", {memerr, dload}); end
        idle_inputs();
    endtask

    task automatic test_reset_midaccess;
        dREN = 1; daddr = 32'h44; ramstate = BUSY;
        tick();
        checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL rmid_bus got %b want 1", ramREN); end
        #2;
        nRST = 0;
        #1;
        checks++; if ({ramREN, dwait, memerr} !== 3'b010) begin errors++; $display("FAIL rmid_async got %b want 010", {ramREN, dwait, memerr}); end
        checks++; if (ramaddr !== 32'h0) begin errors++; $display("FAIL rmid_addr got %h want 0", ramaddr); end
        #2;
        nRST = 1;
        ramstate = ACCESS; ramload = 32'hCAFEF00D;
        tick();
        checks++; if ({ramREN, ramaddr} !== {1'b1, 32'h44}) begin errors++; $display("FAIL rmid_rebus got %h want 100000044", {ramREN, ramaddr}); end
        tick();
        checks++; if ({dwait, dload} !== {1'b0, 32'hCAFEF00D}) begin errors++; $display("FAIL rmid_done got %h want 0cafef00d", {dwait, dload}); end
        idle_inputs();
        tick();
    endtask

    task automatic test_rd_wr_conflict;
        dREN = 1; dWEN = 1; daddr = 32'h10; dstore = 32'h12345678;
        ramstate = ACCESS;
        checks++; if (memerr !== 1'b0) begin errors++; $display("FAIL rw_pre_memerr got %b want 0", memerr); end
        tick();
        checks++; if ({ramWEN, ramREN, memerr} !== 3'b101) begin errors++; $display("FAIL rw_bus got %b want 101", {ramWEN, ramREN, memerr}); end
        checks++; if ({ramaddr, ramstore} !== {32'h10, 32'h12345678}) begin errors++; $display("FAIL rw_data got %h want 0000001012345678", {ramaddr, ramstore}); end
        tick();
        checks++; if (dwait !== 1'b0) begin errors++; $display("FAIL rw_done got %b want 0", dwait); end
        idle_inputs();
        tick();
        checks++; if ({memerr, dwait} !== 2'b11) begin errors++; $display("FAIL rw_after got %b want 11", {memerr, dwait}); end
    endtask

    initial begin
        test_reset();
        test_iread();
        test_dwrite_busy();
        test_arbitration();
        test_drop_midaccess();
        test_timeout();
        test_reset_midaccess();
        test_rd_wr_conflict();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
